tag_ras_unit: RTL and testbench

Second-generation target address generator for the ID stage of the SPARC-subset pipeline.
- Computes CALL and branch targets for a configurable address width.
- Adds a return-address stack (RAS) so that return instructions (JMPL %o7+8 class) get a predicted target.
- Registers its result one cycle later toward the IF-stage PC mux, with stall and flush control.

---
 rtl/tag_ras_unit.sv | 135 +++++++++++++
 tb/tb_tag_ras_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tag_ras_unit.sv
// Purpose: ID-stage target generator (branch/CALL) with a return-address stack for JMPL returns.
// Latency: one cycle from the ID inputs to the registered target outputs.
// Backpressure: stall freezes every register; flush squashes the ID request and leaves the RAS intact.
module tag_ras_unit #(
  parameter int AW        = 32,
  parameter int D22W      = 22,
  parameter int D30W      = 30,
  parameter int RAS_DEPTH = 4,
  parameter int CW        = $clog2(RAS_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   pc_id,
  input  logic [D22W-1:0] disp22,
  input  logic [D30W-1:0] disp30,
  input  logic            call_id,
  input  logic            bi_id,
  input  logic            ret_id,
  input  logic            stall,
  input  logic            flush,
  output logic [AW-1:0]   tag_out,
  output logic            tag_valid,
  output logic [1:0]      tag_sel,
  output logic            ras_miss,
  output logic [CW-1:0]   ras_count
);

  localparam int PW = $clog2(RAS_DEPTH);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_CALL = 2'b10;
  localparam logic [1:0] SEL_RET  = 2'b11;

  logic [AW-1:0] tag_q, tag_d;
  logic          valid_q, valid_d;
  logic [1:0]    sel_q, sel_d;
  logic          miss_q, miss_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] tp_q, tp_d;
  logic [AW-1:0] ras_q [RAS_DEPTH];

  logic [AW-1:0] br_off, call_off;
  logic [AW-1:0] br_tgt, call_tgt, ret_addr;
  logic [PW-1:0] push_ptr;
  logic          push;

  // Sign-extend the word displacements to AW, scale to bytes, and form all candidate targets.
  always_comb begin
    br_off   = {{(AW-D22W){disp22[D22W-1]}}, disp22};
    call_off = {{(AW-D30W){disp30[D30W-1]}}, disp30};
    br_tgt   = pc_id + (br_off << 2);
    call_tgt = pc_id + (call_off << 2);
    ret_addr = pc_id + AW'(8);
    push_ptr = tp_q + PW'(1);
  end

  // Next-state decode: flush beats stall, stall holds everything, otherwise call > ret > branch.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    miss_d  = miss_q;
    cnt_d   = cnt_q;
    tp_d    = tp_q;
    push    = 1'b0;
    if (flush) begin
      tag_d   = '0;
      valid_d = 1'b0;
      sel_d   = SEL_NONE;
      miss_d  = 1'b0;
    end else if (!stall) begin
      tag_d   = '0;
      valid_d = 1'b0;
      sel_d   = SEL_NONE;
      miss_d  = 1'b0;
      if (call_id) begin
        tag_d   = call_tgt;
        valid_d = 1'b1;
        sel_d   = SEL_CALL;
        push    = 1'b1;
        tp_d    = push_ptr;
        // A push while full overwrites the oldest entry, so occupancy saturates.
        if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
      end else if (ret_id) begin
        sel_d = SEL_RET;
        if (cnt_q != '0) begin
          tag_d   = ras_q[tp_q];
          valid_d = 1'b1;
          tp_d    = tp_q - PW'(1);
          cnt_d   = cnt_q - CW'(1);
        end else begin
          miss_d = 1'b1;
        end
      end else if (bi_id) begin
        tag_d   = br_tgt;
        valid_d = 1'b1;
        sel_d   = SEL_BR;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
      sel_q   <= SEL_NONE;
      miss_q  <= 1'b0;
      cnt_q   <= '0;
      tp_q    <= '0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      miss_q  <= miss_d;
      cnt_q   <= cnt_d;
      tp_q    <= tp_d;
    end
  end

  // RAS storage: contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      ras_q[push_ptr] <= ret_addr;
    end
  end

  assign tag_out   = tag_q;
  assign tag_valid = valid_q;
  assign tag_sel   = sel_q;
  assign ras_miss  = miss_q;
  assign ras_count = cnt_q;

endmodule

// File: tb/tb_tag_ras_unit.sv
// Purpose: directed self-checking bench for tag_ras_unit with hand-computed targets.
// Latency: each vector is applied, one clock edge taken, outputs sampled 1ns after the edge.
// Backpressure: stall/flush vectors exercised explicitly.
module tb_tag_ras_unit;

  localparam int AW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc_id;
  logic [21:0]   disp22;
  logic [29:0]   disp30;
  logic          call_id, bi_id, ret_id, stall, flush;
  logic [31:0]   tag_out;
  logic          tag_valid;
  logic [1:0]    tag_sel;
  logic          ras_miss;
  logic [CW-1:0] ras_count;

  int n_chk  = 0;
  int n_fail = 0;

  tag_ras_unit #(.AW(AW), .D22W(22), .D30W(30), .RAS_DEPTH(4), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_id     (pc_id),
    .disp22    (disp22),
    .disp30    (disp30),
    .call_id   (call_id),
    .bi_id     (bi_id),
    .ret_id    (ret_id),
    .stall     (stall),
    .flush     (flush),
    .tag_out   (tag_out),
    .tag_valid (tag_valid),
    .tag_sel   (tag_sel),
    .ras_miss  (ras_miss),
    .ras_count (ras_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset   = 1'b0;
    call_id = 1'b0;
    bi_id   = 1'b0;
    ret_id  = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    pc_id   = '0;
    disp22  = '0;
    disp30  = '0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] t, input logic v,
                            input logic [1:0] s, input logic m, input logic [CW-1:0] c);
    chk({tag, ".tag_out"},   64'(tag_out),   64'(t));
    chk({tag, ".tag_valid"}, 64'(tag_valid), 64'(v));
    chk({tag, ".tag_sel"},   64'(tag_sel),   64'(s));
    chk({tag, ".ras_miss"},  64'(ras_miss),  64'(m));
    chk({tag, ".ras_count"}, 64'(ras_count), 64'(c));
  endtask

  task automatic do_call(input logic [31:0] pc, input logic [29:0] d);
    idle(); pc_id = pc; disp30 = d; call_id = 1'b1;
    step();
  endtask

  task automatic do_ret(input logic [31:0] pc);
    idle(); pc_id = pc; ret_id = 1'b1;
    step();
  endtask

  logic [31:0] exp_ret [4];

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    expect_out("reset", 32'h0, 1'b0, 2'b00, 1'b0, 3'd0);

    // 1: branch with negative displacement
    idle(); pc_id = 32'h100; disp22 = 22'h3FFFFE; bi_id = 1'b1;
    step();
    expect_out("br_neg", 32'hF8, 1'b1, 2'b01, 1'b0, 3'd0);
    idle();
    step();
    expect_out("br_idle", 32'h0, 1'b0, 2'b00, 1'b0, 3'd0);

    // 2: call then return
    do_call(32'h200, 30'h10);
    expect_out("call1", 32'h240, 1'b1, 2'b10, 1'b0, 3'd1);
    do_ret(32'h300);
    expect_out("ret1", 32'h208, 1'b1, 2'b11, 1'b0, 3'd0);

    // 3: overflow, oldest entry (0x18) lost
    for (int i = 1; i <= 5; i++) begin
      do_call(32'(i * 16), 30'h0);
      chk("ovf_call.tag", 64'(tag_out), 64'(i * 16));
    end
    chk("ovf.count", 64'(ras_count), 64'd4);
    exp_ret[0] = 32'h58; exp_ret[1] = 32'h48; exp_ret[2] = 32'h38; exp_ret[3] = 32'h28;
    for (int i = 0; i < 4; i++) begin
      do_ret(32'h1000);
      expect_out("ovf_ret", exp_ret[i], 1'b1, 2'b11, 1'b0, CW'(3 - i));
    end
    do_ret(32'h1000);
    expect_out("ovf_miss", 32'h0, 1'b0, 2'b11, 1'b1, 3'd0);
    idle();
    step();
    chk("miss_pulse", 64'(ras_miss), 64'd0);

    // 4: priority call > ret > branch
    idle(); pc_id = 32'h400; disp30 = 30'h1; disp22 = 22'h5;
    call_id = 1'b1; bi_id = 1'b1; ret_id = 1'b1;
    step();
    expect_out("prio", 32'h404, 1'b1, 2'b10, 1'b0, 3'd1);
    do_ret(32'h0);
    expect_out("prio_ret", 32'h408, 1'b1, 2'b11, 1'b0, 3'd0);

    // 5: stall and flush
    do_call(32'h500, 30'h0);
    expect_out("pre_stall", 32'h500, 1'b1, 2'b10, 1'b0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      idle(); pc_id = 32'h600; call_id = 1'b1; stall = 1'b1;
      step();
      expect_out("stall", 32'h500, 1'b1, 2'b10, 1'b0, 3'd1);
    end
    idle(); pc_id = 32'h600; call_id = 1'b1; flush = 1'b1;
    step();
    expect_out("flush", 32'h0, 1'b0, 2'b00, 1'b0, 3'd1);
    do_call(32'h600, 30'h0);
    expect_out("post_flush", 32'h600, 1'b1, 2'b10, 1'b0, 3'd2);
    idle(); pc_id = 32'h700; call_id = 1'b1; flush = 1'b1; stall = 1'b1;
    step();
    expect_out("stall_flush", 32'h0, 1'b0, 2'b00, 1'b0, 3'd2);
    do_ret(32'h0);
    expect_out("ras_intact", 32'h608, 1'b1, 2'b11, 1'b0, 3'd1);

    // 6: reset mid-operation
    do_call(32'h700, 30'h0);
    do_call(32'h800, 30'h0);
    chk("pre_reset.count", 64'(ras_count), 64'd3);
    idle(); pc_id = 32'h900; call_id = 1'b1; reset = 1'b1;
    step();
    expect_out("mid_reset", 32'h0, 1'b0, 2'b00, 1'b0, 3'd0);
    do_ret(32'h0);
    expect_out("reset_miss", 32'h0, 1'b0, 2'b11, 1'b1, 3'd0);

    // 7: address wrap-around
    idle(); pc_id = 32'hFFFFFFFC; disp22 = 22'h2; bi_id = 1'b1;
    step();
    expect_out("wrap", 32'h4, 1'b1, 2'b01, 1'b0, 3'd0);

    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
